// File: rtl/wb_mtimer_if.sv
// Wishbone pipelined bus bundle between the data-side interconnect and the
// machine timer slave.
interface wb_mtimer_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stall_o;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic        wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_stall_o, wb_ack_o, wb_dat_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_stall_o, wb_ack_o, wb_dat_o, wb_err_o
  );
endinterface

// File: rtl/wb_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp) as a Wishbone pipelined slave.
// Define MTIMER_CTRL_EN to add the CTRL register (CNT_EN, IRQ_EN) at offset 0x10.
module wb_mtimer #(
  parameter int unsigned PRESCALE  = 1,
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  wb_mtimer_if.slave wb,
  output logic       mtip_o
);
  localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [15:0] ps_cnt_q, ps_cnt_d;
  logic        req_p0, adr_err_p0, wr_p0, tick_p0;
  logic [2:0]  reg_idx_p0;
  logic [31:0] rdata_p0;
  logic        cnt_en, irq_en;
  logic        vld_p1, err_p1;
  logic [31:0] dat_p1;
  logic        unused_adr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Stage p0: request decode and register read on pre-update values
  assign req_p0     = wb.wb_cyc_i & wb.wb_stb_i;
  assign adr_err_p0 = |wb.wb_adr_i[1:0];
  assign reg_idx_p0 = wb.wb_adr_i[4:2];
  assign wr_p0      = req_p0 & ~adr_err_p0 & wb.wb_we_i & (|wb.wb_sel_i);
  assign unused_adr = ^wb.wb_adr_i[31:5];

`ifdef MTIMER_CTRL_EN
  logic [1:0] ctrl_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl_q <= 2'b11;
    end else if (wr_p0 && reg_idx_p0 == 3'd4 && wb.wb_sel_i[0]) begin
      ctrl_q <= wb.wb_dat_i[1:0];
    end
  end

  assign cnt_en = ctrl_q[0];
  assign irq_en = ctrl_q[1];
`else
  assign cnt_en = 1'b1;
  assign irq_en = 1'b1;
`endif

  always_comb begin
    rdata_p0 = '0;
    case (reg_idx_p0)
      3'd0: rdata_p0 = mtime_q[31:0];
      3'd1: rdata_p0 = mtime_q[63:32];
      3'd2: rdata_p0 = mtimecmp_q[31:0];
      3'd3: rdata_p0 = mtimecmp_q[63:32];
`ifdef MTIMER_CTRL_EN
      3'd4: rdata_p0 = {30'd0, ctrl_q};
`endif
      default: rdata_p0 = '0;
    endcase
  end

  // A software write to mtime replaces the increment for the whole 64 bits
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    ps_cnt_d   = ps_cnt_q;
    tick_p0    = cnt_en && (ps_cnt_q == PS_MAX);
    if (cnt_en) ps_cnt_d = tick_p0 ? 16'd0 : ps_cnt_q + 16'd1;
    if (tick_p0) mtime_d = mtime_q + 64'd1;
    if (wr_p0) begin
      case (reg_idx_p0)
        3'd0: mtime_d = {mtime_q[63:32],
                         merge_bytes(mtime_q[31:0], wb.wb_dat_i, wb.wb_sel_i)};
        3'd1: mtime_d = {merge_bytes(mtime_q[63:32], wb.wb_dat_i, wb.wb_sel_i),
                         mtime_q[31:0]};
        3'd2: mtimecmp_d = {mtimecmp_q[63:32],
                            merge_bytes(mtimecmp_q[31:0], wb.wb_dat_i, wb.wb_sel_i)};
        3'd3: mtimecmp_d = {merge_bytes(mtimecmp_q[63:32], wb.wb_dat_i, wb.wb_sel_i),
                            mtimecmp_q[31:0]};
        default: ;
      endcase
    end
  end

  // Stage p1: registered state, response and interrupt
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mtime_q    <= '0;
      mtimecmp_q <= CMP_RESET;
      ps_cnt_q   <= '0;
      vld_p1     <= 1'b0;
      err_p1     <= 1'b0;
      dat_p1     <= '0;
      mtip_o     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ps_cnt_q   <= ps_cnt_d;
      vld_p1     <= req_p0 & ~adr_err_p0;
      err_p1     <= req_p0 & adr_err_p0;
      dat_p1     <= (req_p0 && !adr_err_p0) ? rdata_p0 : 32'd0;
      mtip_o     <= (mtime_q >= mtimecmp_q) && irq_en;
    end
  end

  assign wb.wb_stall_o = 1'b0;
  assign wb.wb_ack_o   = vld_p1;
  assign wb.wb_err_o   = err_p1;
  assign wb.wb_dat_o   = dat_p1;
endmodule

// File: tb/tb_wb_mtimer.sv
// Bench for wb_mtimer: two instances (PRESCALE 1 and 4) against a cycle-level
// arithmetic model of mtime/mtimecmp; CTRL tests follow MTIMER_CTRL_EN.
`timescale 1ns/1ps
module tb_wb_mtimer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic [3:0]  sel = '0;
  int          tsel = 0;
  logic        mtip0, mtip1;
  int          errors = 0, checks = 0;
  logic        r_ack, r_err, r_stall, r_pre_ack;
  logic [31:0] r_dat;

  always #5 clk = ~clk;

  wb_mtimer_if bus0();
  wb_mtimer_if bus1();

  assign bus0.wb_cyc_i = cyc;
  assign bus0.wb_stb_i = stb && (tsel == 0);
  assign bus0.wb_we_i  = we;
  assign bus0.wb_adr_i = adr;
  assign bus0.wb_dat_i = wdat;
  assign bus0.wb_sel_i = sel;
  assign bus1.wb_cyc_i = cyc;
  assign bus1.wb_stb_i = stb && (tsel == 1);
  assign bus1.wb_we_i  = we;
  assign bus1.wb_adr_i = adr;
  assign bus1.wb_dat_i = wdat;
  assign bus1.wb_sel_i = sel;

  wb_mtimer #(.PRESCALE(1)) u_dut0 (.wb_clk_i(clk), .wb_rst_i(rst), .wb(bus0.slave), .mtip_o(mtip0));
  wb_mtimer #(.PRESCALE(4)) u_dut1 (.wb_clk_i(clk), .wb_rst_i(rst), .wb(bus1.slave), .mtip_o(mtip1));

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [63:0] t;
    logic [63:0] c;
    logic [31:0] ps;
    logic        cen;
    logic        ien;
    logic        ack;
    logic        err;
    logic        mtip;
    logic [31:0] dat;
  } mstate_t;

  mstate_t ms [2];

  function automatic logic [63:0] put_bytes(input logic [63:0] v, input int half,
                                            input logic [31:0] d, input logic [3:0] be);
    logic [63:0] r;
    int sh;
    r = v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        sh = 32 * half + 8 * b;
        r = (r & ~(64'hFF << sh)) | (64'(d[8*b +: 8]) << sh);
      end
    end
    return r;
  endfunction

  function automatic mstate_t step(input mstate_t s, input int d);
    mstate_t n;
    int p, off;
    bit req, ok, en;
    logic [63:0] rd;
    n = s;
    p = (d == 1) ? 4 : 1;
    if (rst) begin
      n.t = 0; n.c = '1; n.ps = 0; n.cen = 1; n.ien = 1;
      n.ack = 0; n.err = 0; n.mtip = 0; n.dat = 0;
    end else begin
      req = cyc && stb && (tsel == d);
      ok  = req && (adr[1:0] == 2'b00);
      off = int'(adr[4:2]);
      n.ack = ok;
      n.err = req && !ok;
      rd = 0;
      if (off == 0) rd = s.t % 64'h1_0000_0000;
      if (off == 1) rd = s.t / 64'h1_0000_0000;
      if (off == 2) rd = s.c % 64'h1_0000_0000;
      if (off == 3) rd = s.c / 64'h1_0000_0000;
`ifdef MTIMER_CTRL_EN
      if (off == 4) rd = 64'(s.cen) + 2 * 64'(s.ien);
`endif
      n.dat = ok ? rd[31:0] : 32'd0;
      en = s.cen;
      n.ps = en ? (s.ps + 1) % p : s.ps;
      if (en && s.ps == p - 1) n.t = s.t + 1;
      if (ok && we && sel != 0) begin
        if (off < 2) n.t = put_bytes(s.t, off, wdat, sel);
        if (off == 2 || off == 3) n.c = put_bytes(s.c, off - 2, wdat, sel);
`ifdef MTIMER_CTRL_EN
        if (off == 4 && sel[0]) begin n.cen = wdat[0]; n.ien = wdat[1]; end
`endif
      end
      n.mtip = (s.t >= s.c) && s.ien;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) ms[d] <= step(ms[d], d);
  end

  // ---------------- bus driver ----------------
  task automatic xfer(input int d, input bit w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] s);
    @(negedge clk);
    tsel = d; cyc = 1; stb = 1; we = w; adr = a; wdat = wd; sel = s;
    #1;
    r_stall   = d ? bus1.wb_stall_o : bus0.wb_stall_o;
    r_pre_ack = d ? bus1.wb_ack_o : bus0.wb_ack_o;
    @(negedge clk);
    r_ack = d ? bus1.wb_ack_o : bus0.wb_ack_o;
    r_err = d ? bus1.wb_err_o : bus0.wb_err_o;
    r_dat = d ? bus1.wb_dat_o : bus0.wb_dat_o;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic do_reset;
    @(negedge clk); rst = 1;
    @(negedge clk);
    @(negedge clk); rst = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(negedge clk);
    rst = 1; tsel = 0; cyc = 1; stb = 1; we = 0; adr = 0; sel = 4'hF;
    @(negedge clk);
    cyc = 0; stb = 0;
    checks++;
    if (bus0.wb_ack_o !== 1'b0 || bus0.wb_err_o !== 1'b0 || bus0.wb_dat_o !== 32'd0 || mtip0 !== 1'b0)
      begin errors++; $display("FAIL reset_outputs: got ack=%b err=%b dat=%h mtip=%b want 0 0 0 0",
                               bus0.wb_ack_o, bus0.wb_err_o, bus0.wb_dat_o, mtip0); end
    rst = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checks++;
      if (mtip0 !== 1'b0 || mtip1 !== 1'b0)
        begin errors++; $display("FAIL idle_mtip: got %b/%b want 0/0", mtip0, mtip1); end
    end
    xfer(0, 0, 32'h0, 32'h0, 4'hF);
    checks++;
    if (r_ack !== 1'b1 || !(r_dat == 32'd9 || r_dat == 32'd10) || r_dat !== ms[0].dat)
      begin errors++; $display("FAIL reset_mtime_lo: got ack=%b dat=%0d want ack=1 dat=%0d", r_ack, r_dat, ms[0].dat); end
    xfer(0, 0, 32'hC, 32'h0, 4'hF);
    checks++;
    if (r_dat !== 32'hFFFF_FFFF)
      begin errors++; $display("FAIL reset_cmp_hi0: got %h want ffffffff", r_dat); end
    xfer(1, 0, 32'hC, 32'h0, 4'hF);
    checks++;
    if (r_dat !== 32'hFFFF_FFFF)
      begin errors++; $display("FAIL reset_cmp_hi1: got %h want ffffffff", r_dat); end
    checks++;
    if (mtip0 !== 1'b0) begin errors++; $display("FAIL reset_mtip_end: got %b want 0", mtip0); end
  endtask

  task automatic test_carry;
    xfer(0, 1, 32'h0, 32'hFFFF_FFFF, 4'hF);
    checks++;
    if (r_ack !== 1'b1 || r_err !== 1'b0 || r_stall !== 1'b0)
      begin errors++; $display("FAIL carry_write: got ack=%b err=%b stall=%b want 1 0 0", r_ack, r_err, r_stall); end
    xfer(0, 0, 32'h4, 32'h0, 4'hF);
    checks++;
    if (r_pre_ack !== 1'b0 || r_ack !== 1'b1 || r_stall !== 1'b0)
      begin errors++; $display("FAIL carry_timing: got pre_ack=%b ack=%b stall=%b want 0 1 0", r_pre_ack, r_ack, r_stall); end
    checks++;
    if (r_dat !== 32'd1 || r_dat !== ms[0].dat)
      begin errors++; $display("FAIL carry_hi: got %h want 00000001", r_dat); end
  endtask

  task automatic test_mtip;
    bit rose = 0;
    xfer(0, 1, 32'h4, 32'h0, 4'hF);
    xfer(0, 1, 32'h0, 32'h0, 4'hF);
    xfer(0, 1, 32'h8, 32'h20, 4'hF);
    xfer(0, 1, 32'hC, 32'h0, 4'hF);
    for (int i = 0; i < 60 && !rose; i++) begin
      @(negedge clk);
      checks++;
      if (mtip0 !== ms[0].mtip)
        begin errors++; $display("FAIL mtip_track: got %b want %b (mtime=%0h)", mtip0, ms[0].mtip, ms[0].t); end
      if (mtip0 === 1'b1) begin
        rose = 1;
        checks++;
        if (ms[0].t !== 64'h21)
          begin errors++; $display("FAIL mtip_rise_time: got mtime=%0h at rise want 21", ms[0].t); end
      end
    end
    checks++;
    if (!rose) begin errors++; $display("FAIL mtip_rise: got no rise want rise within 60 cycles"); end
    xfer(0, 1, 32'h8, 32'hFFFF_FFFF, 4'hF);
    checks++;
    if (mtip0 !== 1'b1) begin errors++; $display("FAIL mtip_hold: got %b want 1", mtip0); end
    @(negedge clk);
    checks++;
    if (mtip0 !== 1'b0) begin errors++; $display("FAIL mtip_drop: got %b want 0", mtip0); end
  endtask

  task automatic test_prescale;
    logic [31:0] v1;
    bit found = 0;
    xfer(1, 0, 32'h0, 32'h0, 4'hF);
    v1 = r_dat;
    for (int i = 0; i < 6; i++) @(negedge clk);
    xfer(1, 0, 32'h0, 32'h0, 4'hF);
    checks++;
    if (r_dat - v1 !== 32'd2 || r_dat !== ms[1].dat)
      begin errors++; $display("FAIL prescale_rate: got delta=%0d want 2 over 8 cycles", r_dat - v1); end
    for (int i = 0; i < 8 && !found; i++) begin
      if (ms[1].ps == 2) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL prescale_align: got no tick phase want phase 2 within 8 cycles"); end
    xfer(1, 1, 32'h0, 32'h100, 4'hF);
    xfer(1, 0, 32'h0, 32'h0, 4'hF);
    checks++;
    if (r_dat !== 32'h100 || r_dat !== ms[1].dat)
      begin errors++; $display("FAIL prescale_tick_write: got %h want 00000100", r_dat); end
  endtask

  task automatic test_sel_err;
    do_reset();
    xfer(0, 1, 32'h8, 32'hAABB_CCDD, 4'b0010);
    xfer(0, 0, 32'h8, 32'h0, 4'hF);
    checks++;
    if (r_dat !== 32'hFFFF_CCFF) begin errors++; $display("FAIL sel_byte: got %h want ffffccff", r_dat); end
    xfer(0, 1, 32'h9, 32'h0, 4'hF);
    checks++;
    if (r_err !== 1'b1 || r_ack !== 1'b0 || r_dat !== 32'd0)
      begin errors++; $display("FAIL err_misaligned: got err=%b ack=%b dat=%h want 1 0 0", r_err, r_ack, r_dat); end
    xfer(0, 0, 32'h8, 32'h0, 4'hF);
    checks++;
    if (r_dat !== 32'hFFFF_CCFF) begin errors++; $display("FAIL err_no_write: got %h want ffffccff", r_dat); end
    xfer(0, 1, 32'h8, 32'h0, 4'h0);
    checks++;
    if (r_ack !== 1'b1) begin errors++; $display("FAIL sel0_ack: got %b want 1", r_ack); end
    xfer(0, 0, 32'h8, 32'h0, 4'h0);
    checks++;
    if (r_dat !== 32'hFFFF_CCFF) begin errors++; $display("FAIL sel0_no_write: got %h want ffffccff", r_dat); end
    xfer(0, 1, 32'h14, 32'hFFFF_FFFF, 4'hF);
    xfer(0, 0, 32'h14, 32'h0, 4'hF);
    checks++;
    if (r_ack !== 1'b1 || r_dat !== 32'd0)
      begin errors++; $display("FAIL reserved: got ack=%b dat=%h want 1 0", r_ack, r_dat); end
  endtask

  task automatic test_back_to_back;
    bit          wv [8];
    logic [31:0] av [8];
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (bus0.wb_ack_o !== ms[0].ack || bus0.wb_err_o !== ms[0].err ||
            (!wv[i-1] && ms[0].ack && bus0.wb_dat_o !== ms[0].dat))
          begin errors++; $display("FAIL b2b_%0d: got ack=%b err=%b dat=%h want %b %b %h",
                                   i - 1, bus0.wb_ack_o, bus0.wb_err_o, bus0.wb_dat_o, ms[0].ack, ms[0].err, ms[0].dat); end
        if (i == 2) begin
          checks++;
          if (bus0.wb_dat_o !== 32'h1234_5678)
            begin errors++; $display("FAIL b2b_readback: got %h want 12345678", bus0.wb_dat_o); end
        end
      end
      if (i < 8) begin
        if (i == 0)      begin wv[i] = 1; av[i] = 32'h8; end
        else if (i == 1) begin wv[i] = 0; av[i] = 32'h8; end
        else begin
          wv[i] = 1'($urandom_range(1, 0));
          av[i] = {27'd0, 3'($urandom_range(7, 0)), 2'b00};
          if (i == 5) av[i][1:0] = 2'b10;
        end
        tsel = 0; cyc = 1; stb = 1; we = wv[i]; adr = av[i];
        wdat = (i == 0) ? 32'h1234_5678 : $urandom; sel = (i == 0) ? 4'hF : 4'($urandom_range(15, 0));
      end else begin
        cyc = 0; stb = 0; we = 0;
      end
    end
  endtask

  task automatic test_ctrl;
    logic [31:0] v1;
    do_reset();
`ifdef MTIMER_CTRL_EN
    xfer(0, 1, 32'h10, 32'h0, 4'h1);
    xfer(0, 0, 32'h0, 32'h0, 4'hF);
    v1 = r_dat;
    for (int i = 0; i < 20; i++) @(negedge clk);
    xfer(0, 0, 32'h0, 32'h0, 4'hF);
    checks++;
    if (r_dat !== v1) begin errors++; $display("FAIL ctrl_freeze: got %h want %h", r_dat, v1); end
    xfer(0, 1, 32'h8, 32'h0, 4'hF);
    xfer(0, 1, 32'hC, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) @(negedge clk);
    checks++;
    if (mtip0 !== 1'b0) begin errors++; $display("FAIL ctrl_irq_off: got %b want 0", mtip0); end
    xfer(0, 1, 32'h10, 32'h2, 4'h1);
    checks++;
    if (mtip0 !== 1'b0) begin errors++; $display("FAIL ctrl_irq_early: got %b want 0", mtip0); end
    @(negedge clk);
    checks++;
    if (mtip0 !== 1'b1) begin errors++; $display("FAIL ctrl_irq_on: got %b want 1", mtip0); end
    xfer(0, 0, 32'h10, 32'h0, 4'hF);
    checks++;
    if (r_dat !== 32'h2) begin errors++; $display("FAIL ctrl_read: got %h want 00000002", r_dat); end
`else
    xfer(0, 1, 32'h10, 32'hFFFF_FFFF, 4'hF);
    xfer(0, 0, 32'h10, 32'h0, 4'hF);
    checks++;
    if (r_ack !== 1'b1 || r_dat !== 32'd0)
      begin errors++; $display("FAIL ctrl_absent: got ack=%b dat=%h want 1 0", r_ack, r_dat); end
    xfer(0, 0, 32'h0, 32'h0, 4'hF);
    v1 = r_dat;
    xfer(0, 0, 32'h0, 32'h0, 4'hF);
    checks++;
    if (r_dat - v1 !== 32'd2) begin errors++; $display("FAIL ctrl_absent_count: got delta=%0d want 2", r_dat - v1); end
`endif
  endtask

  task automatic test_random;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      int d;
      bit w;
      logic [31:0] a;
      d = int'($urandom_range(1, 0));
      w = 1'($urandom_range(1, 0));
      a = {27'd0, 3'($urandom_range(7, 0)), 2'b00};
      if ($urandom_range(7, 0) == 0) a[1:0] = 2'($urandom_range(3, 1));
      xfer(d, w, a, $urandom, 4'($urandom_range(15, 0)));
      checks++;
      if (r_ack !== ms[d].ack || r_err !== ms[d].err || r_stall !== 1'b0 ||
          (!w && ms[d].ack && r_dat !== ms[d].dat) ||
          (d == 0 && mtip0 !== ms[0].mtip) || (d == 1 && mtip1 !== ms[1].mtip))
        begin errors++; $display("FAIL random_%0d: dut%0d adr=%h we=%b got ack=%b err=%b dat=%h want %b %b %h",
                                 i, d, a, w, r_ack, r_err, r_dat, ms[d].ack, ms[d].err, ms[d].dat); end
      for (int k = int'($urandom_range(2, 0)); k > 0; k--) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_mtip();
    test_prescale();
    test_sel_err();
    test_back_to_back();
    test_ctrl();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/wb_mtimer.md
Name: wb_mtimer

Overview:
- Wishbone pipelined slave implementing the RISC-V machine timer (mtime/mtimecmp).
- Sits downstream of the data-bus address decode, as one more data-side slave next to data memory and the debug interface.
- Produces mtip_o, which drives the core's mtip_i input; that input is tied low today.
- Only the offset bits of the address are decoded. The interconnect owns the base address and strobe gating.

Parameters:
- PRESCALE, 1: number of wb_clk_i cycles per mtime increment. Legal range 1..65535; 1 means mtime increments every cycle.
- CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF: reset value of mtimecmp. The all-ones default keeps the interrupt deasserted after reset.

Ports:
- wb_clk_i  input  1  single clock; all logic rises on its posedge.
- wb_rst_i  input  1  synchronous reset, active high.
- wb_cyc_i  input  1  bus cycle valid.
- wb_stb_i  input  1  strobe; already gated by the address decode.
- wb_we_i  input  1  1 = write, 0 = read.
- wb_adr_i  input  32  byte address; only bits [4:0] are used.
- wb_dat_i  input  32  write data.
- wb_sel_i  input  4  byte enables; bit n covers byte lane n.
- wb_stall_o  output  1  tied to 0; the slave never stalls.
- wb_ack_o  output  1  one-cycle acknowledge.
- wb_dat_o  output  32  registered read data.
- wb_err_o  output  1  one-cycle error, returned instead of ack.
- mtip_o  output  1  machine timer interrupt pending, registered.

Behaviour:
- Reset (wb_rst_i=1 at a posedge) sets:
  - mtime=0, mtimecmp=CMP_RESET, prescale counter=0;
  - wb_ack_o=0, wb_err_o=0, wb_dat_o=0, mtip_o=0.
  - Reset overrides any request in flight; no ack or err is issued for it.
- A request is accepted on any cycle with wb_cyc_i & wb_stb_i. Since stall is always 0, back-to-back requests are accepted every cycle.
- Response latency is 1 cycle. Exactly one of ack/err pulses in the cycle after acceptance, with wb_dat_o valid in that same cycle.
- Dropping wb_cyc_i in the cycle after acceptance does not cancel the response; the response is issued anyway.
- Error condition: wb_adr_i[1:0] != 0 gives err=1 and ack=0. No register changes and wb_dat_o=0.
- Register map (offset = wb_adr_i[4:2]):
  - 0x00: mtime[31:0]
  - 0x04: mtime[63:32]
  - 0x08: mtimecmp[31:0]
  - 0x0C: mtimecmp[63:32]
  - 0x10: CTRL (feature-dependent)
  - 0x14..0x1C: reserved; reads return 0, writes are ignored, ack normally.
- Writes honour wb_sel_i byte-wise. sel=0 is acked with no effect.
- Reads ignore wb_sel_i and always return the full word. Read data is the register value before any same-cycle update.
- Prescaler:
  - The counter runs 0..PRESCALE-1 while counting is enabled.
  - tick=1 when the counter is at PRESCALE-1; the counter then wraps to 0.
  - On tick, mtime <= mtime+1 as a 64-bit increment. The carry from bit 31 into bit 32 happens in the same cycle.
  - 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- A write to either mtime half in the tick cycle:
  - the written bytes take the written values;
  - the increment is suppressed for the whole 64 bits that cycle;
  - the prescale counter still wraps normally.
- mtip_o <= (mtime >= mtimecmp), an unsigned 64-bit compare, evaluated on the current register values every cycle. The result is therefore 1 cycle behind register updates.
- No software read-atomicity is provided for mtime. Software uses the hi-lo-hi read sequence.

Optional Feature:
- Macro MTIMER_CTRL_EN.
- Defined: CTRL at 0x10 is implemented.
  - Bit0 CNT_EN, reset 1. When 0, the prescaler and mtime hold.
  - Bit1 IRQ_EN, reset 1. mtip_o <= compare & IRQ_EN.
  - Bits [31:2] read 0. Writes to CTRL honour sel[0].
- Not defined:
  - 0x10 behaves as reserved (reads 0, writes ignored, acked);
  - counting is always enabled;
  - mtip_o is the raw compare result.

Test Plan:
- Reset then idle 10 cycles (PRESCALE=1):
  - mtime reads back 9 or 10 depending on read timing;
  - mtimecmp_hi reads 32'hFFFFFFFF;
  - mtip_o stays 0 throughout.
- Write 0x00=32'hFFFFFFFF, then read 0x04 with PRESCALE=1: mtime_hi reads 1 (carry into the high word), ack arrives 1 cycle after strobe, and stall is never asserted.
- Write mtimecmp=64'h0000_0000_0000_0020 with mtime counting from 0: mtip_o rises exactly 1 cycle after mtime reaches 0x20. Writing mtimecmp_lo=0xFFFFFFFF then drops mtip_o 1 cycle later.
- PRESCALE=4: mtime increments once every 4 cycles. A write to 0x00 of 0x100 landing on a tick cycle gives a readback of 0x100, not 0x101.
- Write 0x08 with sel=4'b0010, data 32'hAABBCCDD, over a reset value of FFFFFFFF: reads back 32'hFFFFCCFF. An access at adr=0x09 gives wb_err_o=1, wb_ack_o=0, and the register is unchanged.
- With MTIMER_CTRL_EN defined:
  - writing CTRL=0 freezes mtime across 20 cycles;
  - with the compare true and IRQ_EN=0, mtip_o=0;
  - setting IRQ_EN=1 raises mtip_o 1 cycle later.
  - Without the macro, 0x10 reads 0.
